// File: rtl/hh_membrane_update.sv
// Hodgkin-Huxley membrane update: one Euler step of the membrane potential
// per start pulse. Ionic currents come from a single shared multiplier that
// is stepped through a fixed 12-state sequence.
//
// state | meaning
// IDLE  | waiting for start, inputs not yet latched
// MSQ   | t = m*m/1000
// MCU   | t = t*m/1000
// M3H   | a = t*h/1000            (m^3 h)
// NSQ   | t = n*n/1000
// NCU   | t = t*n/1000
// N4    | b = t*n/1000            (n^4)
// GNA   | g = GNA*a/1000
// INA   | i_na = g*(vs-ENA)
// GK    | g = GK*b/1000
// IK    | i_k = g*(vs-EK)
// IL    | i_l = GL*(vs-EL)
// UPD   | v_acc += dv*dt*256/10000, saturate, pulse done
module hh_membrane_update #(
  parameter int GNA    = 1200,
  parameter int GK     = 360,
  parameter int GL     = 3,
  parameter int ENA    = 50,
  parameter int EK     = -77,
  parameter int EL     = -54,
  parameter int V_INIT = -65
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        m,
  input  logic [15:0]        h,
  input  logic [15:0]        n,
  input  logic signed [15:0] i_ext,
  input  logic [15:0]        dt,
  output logic signed [15:0] v_mem,
  output logic               busy,
  output logic               done
);

  typedef enum logic [3:0] {
    S_IDLE, S_MSQ, S_MCU, S_M3H, S_NSQ, S_NCU, S_N4,
    S_GNA, S_INA, S_GK, S_IK, S_IL, S_UPD
  } state_t;

  localparam logic signed [31:0] GNA_C   = 32'(GNA);
  localparam logic signed [31:0] GK_C    = 32'(GK);
  localparam logic signed [31:0] GL_C    = 32'(GL);
  localparam logic signed [31:0] ENA_C   = 32'(ENA);
  localparam logic signed [31:0] EK_C    = 32'(EK);
  localparam logic signed [31:0] EL_C    = 32'(EL);
  localparam logic signed [31:0] VACC_RST = 32'(V_INIT * 256);
  localparam logic signed [47:0] VACC_MAX = 48'sd15360;
  localparam logic signed [47:0] VACC_MIN = -48'sd25600;
  localparam logic signed [31:0] K1000   = 32'sd1000;
  localparam logic signed [47:0] K256    = 48'sd256;
  localparam logic signed [47:0] K10000  = 48'sd10000;

  state_t             state;
  logic [15:0]        m_q, h_q, n_q, dt_q;
  logic signed [15:0] iext_q, vs;
  logic signed [31:0] t, a, b, g, i_na, i_k, i_l, v_acc;

  logic signed [31:0] mul_a, mul_b, prod, quot, vs_ext;
  logic signed [31:0] dv;
  logic signed [47:0] dv48, dt48, delta, sum;
  logic signed [31:0] v_acc_next;

  // Membrane potential in mV is the floor of v_acc/256; v_acc stays within
  // [-25600, 15360], so bits [23:8] hold the full signed result.
  assign v_mem  = v_acc[23:8];
  assign vs_ext = 32'(vs);

  // Operand selection for the shared multiplier; divide-by-1000 rescales gates.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_MSQ: begin mul_a = $signed({16'b0, m_q}); mul_b = $signed({16'b0, m_q}); end
      S_MCU: begin mul_a = t;                     mul_b = $signed({16'b0, m_q}); end
      S_M3H: begin mul_a = t;                     mul_b = $signed({16'b0, h_q}); end
      S_NSQ: begin mul_a = $signed({16'b0, n_q}); mul_b = $signed({16'b0, n_q}); end
      S_NCU: begin mul_a = t;                     mul_b = $signed({16'b0, n_q}); end
      S_N4:  begin mul_a = t;                     mul_b = $signed({16'b0, n_q}); end
      S_GNA: begin mul_a = GNA_C;                 mul_b = a;                     end
      S_INA: begin mul_a = g;                     mul_b = vs_ext - ENA_C;        end
      S_GK:  begin mul_a = GK_C;                  mul_b = b;                     end
      S_IK:  begin mul_a = g;                     mul_b = vs_ext - EK_C;         end
      S_IL:  begin mul_a = GL_C;                  mul_b = vs_ext - EL_C;         end
      default: ;
    endcase
    prod = mul_a * mul_b;
    quot = prod / K1000;
  end

  // Euler step: the dv*dt*256 product needs 48 bits before the /10000.
  always_comb begin
    dv    = 32'(iext_q) - i_na - i_k - i_l;
    dv48  = 48'(dv);
    dt48  = $signed({32'b0, dt_q});
    delta = (dv48 * dt48 * K256) / K10000;
    sum   = 48'(v_acc) + delta;
    if (sum > VACC_MAX)      v_acc_next = 32'(VACC_MAX);
    else if (sum < VACC_MIN) v_acc_next = 32'(VACC_MIN);
    else                     v_acc_next = sum[31:0];
  end

  // Sequencer, operand latches and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      v_acc  <= VACC_RST;
      m_q    <= '0;
      h_q    <= '0;
      n_q    <= '0;
      dt_q   <= '0;
      iext_q <= '0;
      vs     <= '0;
      t      <= '0;
      a      <= '0;
      b      <= '0;
      g      <= '0;
      i_na   <= '0;
      i_k    <= '0;
      i_l    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          m_q    <= (m > 16'd1000) ? 16'd1000 : m;
          h_q    <= (h > 16'd1000) ? 16'd1000 : h;
          n_q    <= (n > 16'd1000) ? 16'd1000 : n;
          iext_q <= i_ext;
          dt_q   <= dt;
          vs     <= v_mem;
          busy   <= 1'b1;
          state  <= S_MSQ;
        end
        S_MSQ: begin t    <= quot; state <= S_MCU; end
        S_MCU: begin t    <= quot; state <= S_M3H; end
        S_M3H: begin a    <= quot; state <= S_NSQ; end
        S_NSQ: begin t    <= quot; state <= S_NCU; end
        S_NCU: begin t    <= quot; state <= S_N4;  end
        S_N4:  begin b    <= quot; state <= S_GNA; end
        S_GNA: begin g    <= quot; state <= S_INA; end
        S_INA: begin i_na <= prod; state <= S_GK;  end
        S_GK:  begin g    <= quot; state <= S_IK;  end
        S_IK:  begin i_k  <= prod; state <= S_IL;  end
        S_IL:  begin i_l  <= prod; state <= S_UPD; end
        S_UPD: begin
          v_acc <= v_acc_next;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hh_membrane_update.sv
// Testbench for hh_membrane_update: directed and random Euler steps checked
// against an arithmetic reference of the membrane equations.
module tb_hh_membrane_update;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [15:0]        m = '0, h = '0, n = '0, dt = '0;
  logic signed [15:0] i_ext = '0;
  logic signed [15:0] v_mem;
  logic               busy, done;

  int    total = 0;
  int    bad = 0;
  longint vacc_model = -16640;

  hh_membrane_update dut (
    .clk(clk), .reset(reset), .start(start),
    .m(m), .h(h), .n(n), .i_ext(i_ext), .dt(dt),
    .v_mem(v_mem), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One Euler step from the membrane equations with integer arithmetic
  // (SV division of signed values truncates toward zero, as required).
  function automatic longint model_step(input longint vacc, input longint mi,
      input longint hi, input longint ni, input longint ie, input longint dti);
    longint mc, hc, nc, vs, gate_na, gate_k, ina, ik, il, dv, nv;
    mc = (mi > 1000) ? 1000 : mi;
    hc = (hi > 1000) ? 1000 : hi;
    nc = (ni > 1000) ? 1000 : ni;
    vs = vacc >>> 8;
    gate_na = ((mc * mc / 1000) * mc / 1000) * hc / 1000;
    gate_k  = (((nc * nc / 1000) * nc / 1000) * nc) / 1000;
    ina = (1200 * gate_na / 1000) * (vs - 50);
    ik  = (360 * gate_k / 1000) * (vs + 77);
    il  = 3 * (vs + 54);
    dv  = ie - ina - ik - il;
    nv  = vacc + (dv * dti * 256) / 10000;
    if (nv > 15360) nv = 15360;
    if (nv < -25600) nv = -25600;
    return nv;
  endfunction

  task automatic do_step(input string tag, input int mi, input int hi,
                         input int ni, input int ie, input int dti,
                         input bit hold);
    int  k;
    bit  got;
    bit  busy_ok;
    m = mi[15:0]; h = hi[15:0]; n = ni[15:0];
    i_ext = ie[15:0]; dt = dti[15:0];
    start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_e0"}, busy, 1);
    if (!hold) start = 1'b0;
    k = 0; got = 0; busy_ok = 1;
    while (k < 20 && !got) begin
      @(posedge clk); #1;
      k++;
      if (done === 1'b1) got = 1;
      else if (busy !== 1'b1) busy_ok = 0;
    end
    start = 1'b0;
    check({tag, "_latency"}, got ? k : -1, 12);
    check({tag, "_busy_held"}, busy_ok, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    vacc_model = model_step(vacc_model, mi, hi, ni, ie, dti);
    check({tag, "_v_mem"}, v_mem, vacc_model >>> 8);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    // Reset state, with start asserted alongside reset (reset wins).
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    check("rst_v_mem", v_mem, -65);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 0);

    // Rest: delta truncates to zero.
    do_step("rest", 53, 596, 318, 0, 10, 0);
    check("rest_abs", v_mem, -65);

    // Current step from rest.
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0; vacc_model = -16640;
    do_step("cur", 53, 596, 318, 100, 1000, 0);
    check("cur_abs", v_mem, -56);

    // Saturation at both rails.
    do_step("sat_hi", 53, 596, 318, 32767, 65535, 0);
    check("sat_hi_abs", v_mem, 60);
    do_step("sat_lo", 53, 596, 318, -32768, 65535, 0);
    check("sat_lo_abs", v_mem, -100);

    // Start held high through the step: one done only.
    do_step("hold", 300, 500, 400, 50, 500, 1);

    // Reset while the GNA stage is executing.
    m = 16'd400; h = 16'd400; n = 16'd400; i_ext = 16'sd2000; dt = 16'd2000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vacc_model = -16640;
    check("abort_busy", busy, 0);
    check("abort_v_mem", v_mem, -65);
    begin
      bit saw_done;
      saw_done = 0;
      repeat (14) begin
        @(posedge clk); #1;
        if (done === 1'b1) saw_done = 1;
      end
      check("abort_no_done", saw_done, 0);
    end
    do_step("after_abort", 53, 596, 318, 100, 1000, 0);

    // Gate clamp with dt=0.
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0; vacc_model = -16640;
    do_step("clamp", 2000, 2000, 2000, 0, 0, 0);
    check("clamp_abs", v_mem, -65);

    // Random steps chained through the model.
    for (int i = 0; i < 10; i++) begin
      do_step("rand", int'($urandom_range(0, 1200)), int'($urandom_range(0, 1200)),
              int'($urandom_range(0, 1200)), int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 3000)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
